// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RV32 pipeline. It handles the
//   hazards that forwarding cannot resolve:
//     - load-use RAW between the load in EX and its consumer in ID
//     - multi-cycle mul/div occupancy of EX, including its start handshake
//     - data-memory wait states
//     - taken-branch redirects
//   It also keeps a stall-cycle performance counter and a mul/div watchdog.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   id_rs1/id_rs2         source registers of the ID instruction
//   id_use_rs1/id_use_rs2 the ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read    destination register of the EX instruction; EX holds a load
//   ex_is_muldiv          EX holds a multi-cycle mul/div
//   ex_branch_taken       EX resolved a taken branch or jump
//   mem_stall             data memory is not ready
//   md_done               mul/div result valid (single-cycle pulse)
//   *_stall / *_flush     pipeline register controls (combinational)
//   md_start              start pulse to the mul/div unit (combinational)
//   md_timeout            sticky flag: the watchdog fired
//   stall_cycles          number of cycles with pc_stall=1 (wraps)
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_muldiv,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    input  logic             md_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_stall,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int          WD_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic               lu;

    // x0 never carries a real dependency, so a load to x0 cannot cause a stall.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_stall   = 1'b0;
        md_start       = 1'b0;
        state_d        = state_q;
        wd_d           = wd_q;
        timeout_d      = timeout_q;

        if (mem_stall) begin
            // A memory wait freezes the whole pipe and the sequencer.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (state_q == RUN) begin
            if (ex_is_muldiv) begin
                md_start     = 1'b1;
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                state_d      = MD_WAIT;
                wd_d         = '0;
            end else if (ex_branch_taken) begin
                // ID holds a wrong-path instruction, so load-use is moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end else begin
            // MD_WAIT: md_done wins over a simultaneous watchdog expiry.
            if (md_done) begin
                state_d = RUN;
            end else if (wd_q == WD_LAST) begin
                timeout_d = 1'b1;
                state_d   = RUN;
            end else begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                wd_d         = wd_q + WD_W'(1);
            end
        end

        stall_cycles_d = stall_cycles_q + CNT_W'(pc_stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign md_timeout   = timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_is_muldiv = 0;
    logic        ex_branch_taken = 0, mem_stall = 0, md_done = 0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, md_start, md_timeout;
    logic [31:0] stall_cycles;
    logic [8:0]  outs;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_sc = '0;
    logic [31:0] base;

    // Output vector: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //                ex_mem_stall, ex_mem_flush, mem_wb_stall, md_start
    localparam logic [8:0] NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] MDS  = 9'b1_1_0_1_0_0_1_0_1;
    localparam logic [8:0] MDW  = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] MEM  = 9'b1_1_0_1_0_1_0_1_0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_is_muldiv(ex_is_muldiv), .ex_branch_taken(ex_branch_taken),
        .mem_stall(mem_stall), .md_done(md_done),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_stall(mem_wb_stall), .md_start(md_start),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, ex_mem_flush, mem_wb_stall, md_start};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are already applied (posedge+1); check mid-cycle, then advance.
    task automatic step(input string tag, input logic [8:0] exp);
        #4;
        check(tag, {23'd0, outs}, {23'd0, exp});
        exp_sc = exp_sc + {31'd0, exp[8]};
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_is_muldiv = 0;
        ex_branch_taken = 0; mem_stall = 0; md_done = 0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_outs", {23'd0, outs}, 32'd0);
        check("rst_cnt", stall_cycles, 32'd0);
        check("rst_to", {31'd0, md_timeout}, 32'd0);
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load-use on rs1, then clear
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
        step("lu_rs1", LU);
        ex_mem_read = 0;
        step("lu_after", NONE);
        check("lu_cnt", stall_cycles, 32'd1);

        // Load-use via rs2; matching rs1 without use flag is no hazard
        ex_mem_read = 1; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 5'd5;
        step("lu_rs2", LU);
        id_use_rs2 = 0;
        step("lu_nouse", NONE);

        // Load to x0 never stalls
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
        step("lu_x0", NONE);

        // Branch beats load-use
        ex_rd = 5'd5; id_rs1 = 5'd5; ex_branch_taken = 1;
        step("br_lu", BR);
        clear_inputs();

        // md_done while in RUN is ignored
        md_done = 1;
        step("done_run", NONE);
        md_done = 0;
        check("cnt_a", stall_cycles, exp_sc);

        // Mul/div completing after 5 wait cycles
        base = stall_cycles;
        ex_is_muldiv = 1;
        step("md_start", MDS);
        for (int i = 0; i < 5; i++) step("md_wait", MDW);
        md_done = 1;
        step("md_done", NONE);
        md_done = 0; ex_is_muldiv = 0;
        step("md_after", NONE);
        check("md_cnt", stall_cycles - base, 32'd6);
        check("md_to", {31'd0, md_timeout}, 32'd0);

        // mem_stall inside MD_WAIT freezes the watchdog
        ex_is_muldiv = 1;
        step("ms_start", MDS);
        for (int i = 0; i < 2; i++) step("ms_wait1", MDW);
        mem_stall = 1;
        for (int i = 0; i < 3; i++) step("ms_mem", MEM);
        mem_stall = 0;
        for (int i = 0; i < 3; i++) step("ms_wait2", MDW);
        md_done = 1;
        step("ms_done", NONE);
        md_done = 0; ex_is_muldiv = 0;
        step("ms_after", NONE);
        check("ms_to", {31'd0, md_timeout}, 32'd0);
        check("cnt_b", stall_cycles, exp_sc);

        // Watchdog: 7 stalled wait cycles, 8th releases and sets md_timeout
        ex_is_muldiv = 1;
        step("wd_start", MDS);
        for (int i = 0; i < 7; i++) step("wd_wait", MDW);
        check("wd_to_pre", {31'd0, md_timeout}, 32'd0);
        ex_is_muldiv = 0;
        step("wd_fire", NONE);
        check("wd_to", {31'd0, md_timeout}, 32'd1);
        ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
        step("wd_lu", LU);
        clear_inputs();
        step("wd_idle", NONE);
        check("wd_sticky", {31'd0, md_timeout}, 32'd1);
        check("cnt_c", stall_cycles, exp_sc);

        // Async reset inside MD_WAIT
        ex_is_muldiv = 1;
        step("ar_start", MDS);
        for (int i = 0; i < 2; i++) step("ar_wait", MDW);
        #1;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("ar_outs", {23'd0, outs}, 32'd0);
        check("ar_cnt", stall_cycles, 32'd0);
        check("ar_to", {31'd0, md_timeout}, 32'd0);
        #1;
        rst_n = 1'b1;
        exp_sc = '0;
        @(posedge clk); #1;
        ex_mem_read = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
        step("ar_lu", LU);
        clear_inputs();
        step("ar_idle", NONE);
        check("ar_cnt2", stall_cycles, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
